// File: rtl/shadow_stack_ctrl_pkg.sv
// Shared types and helpers for the shadow return-address stack controller.
package shadow_stack_ctrl_pkg;

    typedef enum logic [1:0] {
        SS_IDLE  = 2'd0,
        SS_ALARM = 2'd1,
        SS_CLEAR = 2'd2
    } shstk_state_e;

    localparam int SHSTK_UDF_W = 8;

    function automatic logic [SHSTK_UDF_W-1:0] udf_sat_inc(input logic [SHSTK_UDF_W-1:0] cnt);
        if (cnt == {SHSTK_UDF_W{1'b1}}) begin
            return cnt;
        end else begin
            return cnt + SHSTK_UDF_W'(1'b1);
        end
    endfunction

endpackage

// File: rtl/shstk_lifo_ram.sv
// Shadow stack storage: DEPTH x AW, one synchronous write port and two
// asynchronous read ports, no reset on the array.
module shstk_lifo_ram #(
    parameter int  DEPTH = 16,
    parameter int  AW    = 32,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [AW-1:0] wdata,
    input  logic [PW-1:0] raddr_a,
    output logic [AW-1:0] rdata_a,
    input  logic [PW-1:0] raddr_b,
    output logic [AW-1:0] rdata_b
);

    logic [AW-1:0] mem_r [DEPTH];

    // Single write port; contents are undefined until written or scrubbed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_r[raddr_a];
    assign rdata_b = mem_r[raddr_b];

endmodule

// File: rtl/shadow_stack_ctrl.sv
// Shadow return-address stack with CFI compare, sticky crash and scrub sequencer.
// Optional debug read port enabled by defining SHADOW_STACK_DBG_READ_EN.
module shadow_stack_ctrl
    import shadow_stack_ctrl_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter int  AW    = 32,
    localparam int PW    = $clog2(DEPTH),
    localparam int DW    = PW + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   call_valid_i,
    input  logic [AW-1:0]          call_addr_i,
    input  logic                   ret_valid_i,
    input  logic [AW-1:0]          ret_addr_i,
    input  logic                   clr_i,
    output logic                   ready_o,
    output logic                   crash_o,
    output logic [DW-1:0]          depth_o,
    output logic                   ovf_o,
    output logic [SHSTK_UDF_W-1:0] udf_cnt_o
`ifdef SHADOW_STACK_DBG_READ_EN
    ,
    input  logic [PW-1:0]          dbg_idx_i,
    output logic [AW-1:0]          dbg_data_o
`endif
);

    localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);
    localparam logic [PW-1:0] IDX_LAST   = PW'(DEPTH - 1);

    shstk_state_e            state_r, state_nxt_s;
    logic [PW-1:0]           ptr_r, top_idx_s, scrub_idx_r, waddr_s, dbg_addr_s;
    logic [DW-1:0]           depth_r;
    logic                    ovf_r;
    logic [SHSTK_UDF_W-1:0]  udf_r;
    logic [AW-1:0]           top_data_s, wdata_s, rd_b_s;
    logic                    push_s, pop_s, udf_s, we_s, mismatch_s;

    assign top_idx_s  = ptr_r - PW'(1'b1);
    assign mismatch_s = pop_s && (top_data_s != ret_addr_i);

    shstk_lifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk_i),
        .we      (we_s),
        .waddr   (waddr_s),
        .wdata   (wdata_s),
        .raddr_a (top_idx_s),
        .rdata_a (top_data_s),
        .raddr_b (dbg_addr_s),
        .rdata_b (rd_b_s)
    );

    // Qualify stack operations: only in IDLE, checking enabled, no scrub request.
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        udf_s  = 1'b0;
        if ((state_r == SS_IDLE) && en_i && !clr_i) begin
            push_s = call_valid_i;
            pop_s  = ret_valid_i && (depth_r != '0);
            udf_s  = ret_valid_i && (depth_r == '0);
        end else begin
            push_s = 1'b0;
            pop_s  = 1'b0;
            udf_s  = 1'b0;
        end
    end

    // RAM write steering: scrub zeros, or push (into the freed top slot on call+ret).
    always_comb begin
        we_s    = 1'b0;
        waddr_s = ptr_r;
        wdata_s = call_addr_i;
        if (state_r == SS_CLEAR) begin
            we_s    = 1'b1;
            waddr_s = scrub_idx_r;
            wdata_s = '0;
        end else if (push_s) begin
            we_s    = 1'b1;
            waddr_s = pop_s ? top_idx_s : ptr_r;
        end else begin
            we_s    = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= SS_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; a compare mismatch lands in ALARM one cycle after the pop.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            SS_IDLE: begin
                if (clr_i)           state_nxt_s = SS_CLEAR;
                else if (mismatch_s) state_nxt_s = SS_ALARM;
                else                 state_nxt_s = SS_IDLE;
            end
            SS_ALARM: begin
                if (clr_i) state_nxt_s = SS_CLEAR;
                else       state_nxt_s = SS_ALARM;
            end
            SS_CLEAR: begin
                if (clr_i)                          state_nxt_s = SS_CLEAR;
                else if (scrub_idx_r == IDX_LAST)   state_nxt_s = SS_IDLE;
                else                                state_nxt_s = SS_CLEAR;
            end
            default: state_nxt_s = SS_IDLE;
        endcase
    end

    // FSM outputs; crash is masked while checking is disabled without losing the alarm.
    always_comb begin
        ready_o = (state_r != SS_CLEAR);
        crash_o = en_i && (state_r == SS_ALARM);
    end

    // Pointer, depth, sticky flags and scrub index.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_r       <= '0;
            depth_r     <= '0;
            ovf_r       <= 1'b0;
            udf_r       <= '0;
            scrub_idx_r <= '0;
        end else if (clr_i) begin
            ptr_r       <= '0;
            depth_r     <= '0;
            ovf_r       <= 1'b0;
            udf_r       <= '0;
            scrub_idx_r <= '0;
        end else begin
            scrub_idx_r <= (state_r == SS_CLEAR) ? scrub_idx_r + PW'(1'b1) : '0;
            if (push_s && !pop_s) begin
                ptr_r <= ptr_r + PW'(1'b1);
                if (depth_r == DEPTH_FULL) begin
                    ovf_r <= 1'b1;
                end else begin
                    depth_r <= depth_r + DW'(1'b1);
                end
            end else if (pop_s && !push_s) begin
                ptr_r   <= top_idx_s;
                depth_r <= depth_r - DW'(1'b1);
            end else begin
                ptr_r   <= ptr_r;
                depth_r <= depth_r;
            end
            if (udf_s) begin
                udf_r <= udf_sat_inc(udf_r);
            end else begin
                udf_r <= udf_r;
            end
        end
    end

    assign depth_o   = depth_r;
    assign ovf_o     = ovf_r;
    assign udf_cnt_o = udf_r;

`ifdef SHADOW_STACK_DBG_READ_EN
    assign dbg_addr_s = top_idx_s - dbg_idx_i;

    // Debug read returns zero for slots beyond the live depth.
    always_comb begin
        if ({1'b0, dbg_idx_i} < depth_r) begin
            dbg_data_o = rd_b_s;
        end else begin
            dbg_data_o = '0;
        end
    end
`else
    logic unused_s;
    assign dbg_addr_s = top_idx_s;
    assign unused_s   = ^rd_b_s;
`endif

endmodule

// File: tb/tb_shadow_stack_ctrl.sv
// Scoreboard bench for shadow_stack_ctrl: directed vectors push expected
// post-edge outputs; a monitor pops and compares once per cycle.
module tb_shadow_stack_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1, en = 1'b1, call_valid = 1'b0, ret_valid = 1'b0, clr = 1'b0;
    logic [31:0] call_addr = 32'h0, ret_addr = 32'h0;
    logic        ready, crash, ovf;
    logic [4:0]  depth;
    logic [7:0]  udf_cnt;

    typedef struct packed {
        logic       rdy;
        logic       crash;
        logic [4:0] depth;
        logic       ovf;
        logic [7:0] udf;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    exp_t  mon_e;
    string mon_nm;

    always #5 clk = ~clk;

    shadow_stack_ctrl #(.DEPTH(16), .AW(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .call_valid_i (call_valid),
        .call_addr_i  (call_addr),
        .ret_valid_i  (ret_valid),
        .ret_addr_i   (ret_addr),
        .clr_i        (clr),
        .ready_o      (ready),
        .crash_o      (crash),
        .depth_o      (depth),
        .ovf_o        (ovf),
        .udf_cnt_o    (udf_cnt)
    );

    // Monitor: one expected record per clock, sampled shortly after the edge.
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            n_vec++;
            if (!$isunknown(mon_e.rdy) && ready !== mon_e.rdy) begin
                n_err++;
                $display("FAIL %s ready_o: got %b expected %b", mon_nm, ready, mon_e.rdy);
            end
            if (!$isunknown(mon_e.crash) && crash !== mon_e.crash) begin
                n_err++;
                $display("FAIL %s crash_o: got %b expected %b", mon_nm, crash, mon_e.crash);
            end
            if (!$isunknown(mon_e.depth) && depth !== mon_e.depth) begin
                n_err++;
                $display("FAIL %s depth_o: got %0d expected %0d", mon_nm, depth, mon_e.depth);
            end
            if (!$isunknown(mon_e.ovf) && ovf !== mon_e.ovf) begin
                n_err++;
                $display("FAIL %s ovf_o: got %b expected %b", mon_nm, ovf, mon_e.ovf);
            end
            if (!$isunknown(mon_e.udf) && udf_cnt !== mon_e.udf) begin
                n_err++;
                $display("FAIL %s udf_cnt_o: got %0d expected %0d", mon_nm, udf_cnt, mon_e.udf);
            end
        end
    end

    // Drive one cycle of inputs at the falling edge and queue the post-edge expectation.
    task automatic cyc(input string nm, input logic e, input logic cv, input logic [31:0] ca,
                       input logic rv, input logic [31:0] ra, input logic c, input logic r,
                       input logic x_rdy, input logic x_cr, input logic [4:0] x_dp,
                       input logic x_ov, input logic [7:0] x_ud);
        exp_t ex;
        @(negedge clk);
        en = e; call_valid = cv; call_addr = ca; ret_valid = rv; ret_addr = ra; clr = c; rst = r;
        ex.rdy = x_rdy; ex.crash = x_cr; ex.depth = x_dp; ex.ovf = x_ov; ex.udf = x_ud;
        exp_q.push_back(ex);
        name_q.push_back(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // reset and idle
        cyc("reset",      1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 8'd0);
        cyc("idle0",      1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'd0);
        cyc("en0_call",   1'b0, 1'b1, 32'h9999_0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'd0);
        cyc("en0_ret",    1'b0, 1'b0, 32'h0, 1'b1, 32'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'd0);

        // 1) matched call/return pairs
        cyc("t1_push_a",  1'b1, 1'b1, 32'h8000_0104, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 8'd0);
        cyc("t1_push_b",  1'b1, 1'b1, 32'h8000_0200, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0, 8'd0);
        cyc("t1_ret_b",   1'b1, 1'b0, 32'h0, 1'b1, 32'h8000_0200, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 8'd0);
        cyc("t1_ret_a",   1'b1, 1'b0, 32'h0, 1'b1, 32'h8000_0104, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'd0);
        cyc("t1_idle",    1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'd0);

        // 2) mismatch -> crash one cycle later, stack frozen, en_i masks crash
        cyc("t2_push",    1'b1, 1'b1, 32'h8000_0104, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 8'd0);
        cyc("t2_ret_bad", 1'b1, 1'b0, 32'h0, 1'b1, 32'h8000_0108, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 8'd0);
        cyc("t2_call_frz",1'b1, 1'b1, 32'h3000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 8'd0);
        cyc("t2_ret_frz", 1'b1, 1'b0, 32'h0, 1'b1, 32'h3000, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 8'd0);
        cyc("t2_en0_mask",1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'd0);
        cyc("t2_sticky",  1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 8'd0);
        cyc("t2_clr",     1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 8'd0);
        for (int i = 1; i < 16; i++)
            cyc("t2_scrub", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 8'd0);
        cyc("t2_scrub_done", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'd0);

        // 3) overflow wraps and discards the oldest entry
        for (int k = 0; k <= 16; k++)
            cyc("t3_push", 1'b1, 1'b1, 32'h1000 + 32'(4 * k), 1'b0, 32'h0, 1'b0, 1'b0,
                1'b1, 1'b0, (k >= 15) ? 5'd16 : 5'(k + 1), (k == 16), 8'd0);
        for (int k = 16; k >= 1; k--)
            cyc("t3_ret", 1'b1, 1'b0, 32'h0, 1'b1, 32'h1000 + 32'(4 * k), 1'b0, 1'b0,
                1'b1, 1'b0, 5'(k - 1), 1'b1, 8'd0);

        // 4) underflow counter saturates at 255
        for (int j = 1; j <= 303; j++)
            cyc("t4_udf", 1'b1, 1'b0, 32'h0, 1'b1, 32'h4000, 1'b0, 1'b0,
                1'b1, 1'b0, 5'd0, 1'b1, (j > 255) ? 8'd255 : 8'(j));

        // 5) same-cycle call and return replaces the top
        cyc("t5_push",    1'b1, 1'b1, 32'h1000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 8'd255);
        cyc("t5_callret", 1'b1, 1'b1, 32'h2000, 1'b1, 32'h1000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 8'd255);
        cyc("t5_ret_top", 1'b1, 1'b0, 32'h0, 1'b1, 32'h2000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 8'd255);
        cyc("t5_idle",    1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 8'd255);

        // 6) alarm, scrub, reset mid-scrub
        cyc("t6_push",    1'b1, 1'b1, 32'h5000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 8'd255);
        cyc("t6_ret_bad", 1'b1, 1'b0, 32'h0, 1'b1, 32'h5004, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 8'd255);
        cyc("t6_clr",     1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 8'd0);
        for (int i = 2; i <= 4; i++)
            cyc("t6_scrub", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 8'd0);
        cyc("t6_rst",     1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 8'd0);
        cyc("t6_idle",    1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'd0);

        // 7) clr during scrub restarts the full sweep
        cyc("t7_clr",     1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++)
            cyc("t7_scrub_a", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 8'd0);
        cyc("t7_clr_again", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 8'd0);
        for (int i = 1; i < 16; i++)
            cyc("t7_scrub_b", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 8'd0);
        cyc("t7_done",    1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'd0);
        cyc("t7_push",    1'b1, 1'b1, 32'h7000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 8'd0);
        cyc("t7_ret",     1'b1, 1'b0, 32'h0, 1'b1, 32'h7000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'd0);
        cyc("t7_idle",    1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'd0);

        repeat (3) @(posedge clk);
        #4;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
